// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer sequencer.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Width needed to count sclk edges 0..2*data_w.
  function automatic int unsigned edge_cnt_w(input int unsigned data_w);
    return $clog2(2 * data_w + 1);
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Enable-gated rate divider: single-cycle tick every DIVIDER clocks while en is high.
module spi_tick_gen #(
  parameter int unsigned DIVIDER = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: one DATA_W word per handshake, MSB first.
// Define SPI_MODE_CFG_EN to add per-transfer cpol/cpha inputs (default: fixed mode 0).
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DIVIDER = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              cs_n,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
`ifdef SPI_MODE_CFG_EN
  ,
  input  logic              cpol,
  input  logic              cpha
`endif
);

  localparam int unsigned EW = edge_cnt_w(DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [EW-1:0]     edge_nxt;
  logic              sclk_ph_q, sclk_ph_d;
  logic              mosi_q, mosi_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tick;
  logic              launch, sample;
  logic              cpha_in;
  logic              cpol_act, cpha_act;
  logic              idle_pol;

`ifdef SPI_MODE_CFG_EN
  logic [1:0] mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if ((state_q == IDLE) && start) begin
      mode_d = {cpol, cpha};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= SPI_MODE0;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign cpha_in  = cpha;
  assign cpol_act = mode_q[1];
  assign cpha_act = mode_q[0];
  assign idle_pol = cpol;
`else
  assign cpha_in  = SPI_MODE0[0];
  assign cpol_act = SPI_MODE0[1];
  assign cpha_act = SPI_MODE0[0];
  assign idle_pol = SPI_MODE0[1];
`endif

  spi_tick_gen #(.DIVIDER(DIVIDER)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (busy),
    .tick (tick)
  );

  assign edge_nxt = edge_q + 1'b1;

  // Odd edges lead each bit pair; cpha picks whether that edge launches or samples.
  // In cpha=0 the final trailing edge must not launch, or the word would over-shift.
  always_comb begin
    if (cpha_act) begin
      launch = edge_nxt[0];
      sample = !edge_nxt[0];
    end else begin
      launch = !edge_nxt[0] && (edge_nxt != LAST_EDGE);
      sample = edge_nxt[0];
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_data_d  = rx_data_q;
    edge_d     = edge_q;
    sclk_ph_d  = sclk_ph_q;
    mosi_d     = mosi_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SETUP;
          tx_d      = tx_data;
          rx_d      = '0;
          edge_d    = '0;
          sclk_ph_d = 1'b0;
          if (!cpha_in) begin
            mosi_d = tx_data[DATA_W-1];
          end
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sclk_ph_d = ~sclk_ph_q;
          edge_d    = edge_nxt;
          if (launch) begin
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            mosi_d = cpha_act ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
          end
          if (sample) begin
            rx_d = {rx_q[DATA_W-2:0], miso};
          end
          if (edge_nxt == LAST_EDGE) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d    = IDLE;
          rx_data_d  = rx_q;
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      edge_q     <= '0;
      sclk_ph_q  <= 1'b0;
      mosi_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_data_q  <= rx_data_d;
      edge_q     <= edge_d;
      sclk_ph_q  <= sclk_ph_d;
      mosi_q     <= mosi_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign busy     = !ready;
  assign cs_n     = ready;
  assign sclk     = sclk_ph_q ^ (busy ? cpol_act : idle_pol);
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl (DATA_W=8, DIVIDER=4); SPI_MODE_CFG_EN adds a mode-3 case.
module tb_spi_xfer_ctrl;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       ready;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       cs_n;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cpol;
  logic       cpha;

  logic       loop_en;
  logic [7:0] model_word;
  logic       model_bit;
  int         bit_idx;

  int         pass_cnt  = 0;
  int         total_cnt = 0;
  exp_t       exp_q[$];

  int         cs_cnt, gap_cnt, last_gap, rises;
  logic [7:0] mosi_w;
  int         bad_ready, bad_sclk, mosi_hi;
  logic       prev_sclk, prev_cs;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.DATA_W(8), .DIVIDER(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ready   (ready),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .busy    (busy),
    .cs_n    (cs_n),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso)
`ifdef SPI_MODE_CFG_EN
    ,
    .cpol    (cpol),
    .cpha    (cpha)
`endif
  );

  // Slave model presents the next word bit ahead of each rising sclk edge.
  always_comb begin
    model_bit = 1'b0;
    if (bit_idx < 8) model_bit = model_word[3'(7 - bit_idx)];
  end
  assign miso = loop_en ? mosi : model_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: tracks pin activity and pops the scoreboard on every rx_valid.
  initial begin
    exp_t e;
    cs_cnt = 0; gap_cnt = 0; last_gap = -1; rises = 0; mosi_w = '0; bit_idx = 0;
    bad_ready = 0; bad_sclk = 0; mosi_hi = 0; prev_sclk = 1'b0; prev_cs = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cs_cnt = 0; gap_cnt = 0; rises = 0; mosi_w = '0; bit_idx = 0;
        prev_sclk = sclk; prev_cs = 1'b1;
      end else begin
        if (prev_cs && !cs_n) begin
          last_gap = gap_cnt; gap_cnt = 0; cs_cnt = 0; rises = 0; mosi_w = '0; bit_idx = 0;
        end
        if (!cs_n) cs_cnt++;
        else gap_cnt++;
        if (!prev_sclk && sclk) begin
          rises++;
          mosi_w = {mosi_w[6:0], mosi};
          bit_idx++;
        end
        if (!cs_n && ready) bad_ready++;
        if (cs_n && (sclk !== cpol)) bad_sclk++;
        if (!cs_n && mosi) mosi_hi++;
        if (rx_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rx_valid", 32'(rx_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("rx_data", 32'(rx_data), 32'(e.rx));
            check("cs_low_cycles", 32'(cs_cnt), 32'd72);
            check("sclk_rises", 32'(rises), 32'd8);
            check("mosi_bits", 32'(mosi_w), 32'(e.tx));
          end
        end
        prev_sclk = sclk;
        prev_cs   = cs_n;
      end
    end
  end

  task automatic push(input logic [7:0] rx, input logic [7:0] tx);
    exp_t e;
    e.rx = rx;
    e.tx = tx;
    exp_q.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    start   = 1'b1;
    tx_data = d;
    @(posedge clk);
    #1;
    start   = 1'b0;
    tx_data = ~d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; tx_data = '0; loop_en = 1'b1; model_word = '0;
    cpol = 1'b0; cpha = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0xA5
    loop_en = 1'b1;
    push(8'hA5, 8'hA5);
    do_start(8'hA5);
    drain();

    // All-zero tx, slave returns 0x3C
    loop_en = 1'b0; model_word = 8'h3C; mosi_hi = 0;
    push(8'h3C, 8'h00);
    do_start(8'h00);
    drain();
    check("mosi_stays_low", 32'(mosi_hi), 32'd0);
    loop_en = 1'b1;

    // Back-to-back with start held high
    push(8'h81, 8'h81);
    push(8'h7E, 8'h7E);
    @(negedge clk);
    start = 1'b1; tx_data = 8'h81;
    @(posedge clk);
    #1 tx_data = 8'h7E;
    n = 0;
    @(negedge clk);
    while (!rx_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("b2b_rx_valid_seen", 32'(rx_valid), 32'd1);
    check("b2b_ready_in_valid_cycle", 32'(ready), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    check("b2b_cs_gap", 32'(last_gap), 32'd1);

    // start while busy is ignored
    push(8'h96, 8'h96);
    do_start(8'h96);
    repeat (9) @(negedge clk);
    check("busy_ready_c10", 32'(ready), 32'd0);
    start = 1'b1; tx_data = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    check("busy_ready_c40", 32'(ready), 32'd0);
    start = 1'b1; tx_data = 8'h22;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (100) @(negedge clk);
    check("ignored_no_second_xfer", 32'(busy), 32'd0);

    // Reset at edge 5 of a 0xFF transfer
    do_start(8'hFF);
    repeat (25) @(negedge clk);
    check("mid_xfer_sclk_high", 32'(sclk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(cs_n), 32'd1);
    check("mid_rst_sclk", 32'(sclk), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    push(8'h55, 8'h55);
    do_start(8'h55);
    drain();

`ifdef SPI_MODE_CFG_EN
    // Mode 3 loopback
    @(posedge clk);
    #2 cpol = 1'b1; cpha = 1'b1;
    repeat (2) @(negedge clk);
    check("mode3_sclk_idle", 32'(sclk), 32'd1);
    push(8'hC3, 8'hC3);
    do_start(8'hC3);
    drain();
    @(negedge clk);
    check("mode3_sclk_idle_after", 32'(sclk), 32'd1);
`endif

    repeat (5) @(negedge clk);
    check("ready_low_while_busy", 32'(bad_ready), 32'd0);
    check("sclk_idle_outside_xfer", 32'(bad_sclk), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard stop in case a wait above is not bounded well enough.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI master. It accepts one DATA_W-bit word over a valid/ready handshake and drives cs_n. It paces the transfer with an internal divided-rate tick, generates sclk, shifts MOSI out MSB-first, samples MISO, and returns the received word with a one-cycle rx_valid pulse. It sits between the host-side register/FIFO logic and the SPI pins.

Parameters:
DATA_W, 8, bits per transfer (>=2)
DIVIDER, 4, clk cycles per sclk half-period (>=2)

Ports:
clk  input  1  global clock
rst_n  input  1  asynchronous active-low reset
start  input  1  transfer request; accepted when start&ready
ready  output  1  high in IDLE; controller can accept a word
tx_data  input  DATA_W  word to send; captured on accept
rx_data  output  DATA_W  received word; holds until the next rx_valid
rx_valid  output  1  one-cycle pulse when rx_data updates
busy  output  1  high in every state except IDLE
cs_n  output  1  chip select, active low
sclk  output  1  serial clock
mosi  output  1  serial data out
miso  input  1  serial data in

Behaviour:
- Interface as decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: ready=1, busy=0, cs_n=1, sclk=0, mosi=0, rx_valid=0, rx_data=0. State=IDLE, counters=0.
- Tick: the divide counter runs 0..DIVIDER-1 while busy. tick=1 when count==DIVIDER-1. The counter is held at 0 in IDLE.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE: on start&ready, capture tx_data into the shift register. Next cycle: SETUP, cs_n=0, busy=1, ready=0, mosi=tx_data[DATA_W-1].
- SETUP: on tick go to SHIFT. Gives a setup time of DIVIDER cycles before the first edge.
- SHIFT: each tick toggles sclk and increments the edge counter.
  - Rising edge (odd count): sample miso into the rx shift register LSB, shifting left.
  - Falling edge (even count): shift the tx register left; mosi = new MSB.
  - After edge 2*DATA_W (sclk back at 0), go to HOLD. No MOSI shift occurs on the final falling edge.
- HOLD: on tick go to IDLE. In that same transition: cs_n=1, ready=1, busy=0, rx_data=assembled word, rx_valid=1 for one cycle.
- cs_n low duration per transfer = DIVIDER*(2*DATA_W+2) clk cycles; 72 for the defaults.
- Exactly DATA_W rising sclk edges per transfer. sclk is never high outside SHIFT.
- Back-to-back: start may be high in the rx_valid cycle and is accepted. cs_n is then high for exactly 1 cycle between words.
- start while busy is ignored: no capture, no queueing.
- tx_data changes after accept have no effect.
- rst_n asserted mid-transfer: all outputs return to their reset values immediately. The partial word is discarded and no rx_valid is produced.

Optional Feature:
SPI_MODE_CFG_EN.
- Defined: adds input ports cpol and cpha (1 bit each), captured on accept.
  - sclk idles at cpol; sclk toggles are relative to cpol.
  - cpha=0: timing is as in Behaviour.
  - cpha=1: mosi is updated on the first edge of each pair and miso is sampled on the second edge. mosi = MSB is driven at the first edge, not at SETUP entry. Edge counts and cs_n duration are unchanged.
- Undefined: no cpol/cpha ports; behaviour is fixed mode 0 (cpol=0, cpha=0).

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, SHIFT, HOLD);
  - a function returning the edge-counter width, $clog2(2*DATA_W+1);
  - the mode constants SPI_MODE0..SPI_MODE3.
- One sub-module, spi_tick_gen: enable-gated, count-clearing divider producing the single-cycle tick. Parameter DIVIDER; ports clk, rst_n, en, tick.
- FSM, shift registers and pin drivers stay in spi_xfer_ctrl.

Test Plan:
- tx_data=0xA5 with miso looped from mosi -> rx_data=0xA5 and one rx_valid pulse. cs_n low exactly 72 cycles, 8 rising sclk edges, mosi sequence 1,0,1,0,0,1,0,1.
- tx_data=0x00 with miso driven by a model returning 0x3C MSB-first -> rx_data=0x3C. mosi stays 0 throughout.
- Two words 0x81, 0x7E with start held high -> second accepted in the rx_valid cycle. cs_n high for 1 cycle between them. rx_data returns 0x81 then 0x7E.
- start pulsed at cycles 10 and 40 of a transfer -> ignored. Exactly one rx_valid, and ready stays 0 until the HOLD exit.
- rst_n low at edge 5 of a 0xFF transfer -> cs_n=1, sclk=0, busy=0 immediately, no rx_valid. A subsequent 0x55 transfer completes correctly.
- With SPI_MODE_CFG_EN, cpol=1 cpha=1, tx 0xC3 loopback -> sclk idles 1, rx_data=0xC3, 8 rising edges, cs_n low 72 cycles.
